logc_expand: RTL and testbench

Inverse of the log-compression stage: converts a compressed `(comp_int, comp_frac)` pair back to a linear fixed-point sample. The pair is an exponent plus a normalised mantissa with an explicit leading one. The block sits at the output end of the compressed path, for example in the display/readback chain or in a loop-back self-check against the FIFO source. It is a 2-stage pipeline with valid/ready handshakes on both sides and full backpressure.

---
 rtl/logc_pkg.sv | 23 ++
 rtl/logc_shift.sv | 46 ++++
 rtl/logc_expand.sv | 116 +++++++++++
 tb/tb_logc_expand.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/logc_pkg.sv
// Shared widths, zero-mantissa encoding and stage-1 record for the log-compression expander.
package logc_pkg;

  localparam int LOGC_DATA_WIDTH  = 48;
  localparam int LOGC_FRAC_WIDTH  = 16;
  localparam int LOGC_NORM_WIDTH  = LOGC_FRAC_WIDTH + 1;
  localparam int LOGC_SHIFT_WIDTH = $clog2(LOGC_DATA_WIDTH);

  localparam logic [LOGC_NORM_WIDTH-1:0] ZERO_MANT = {LOGC_NORM_WIDTH{1'b0}};

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_e;

  typedef struct packed {
    logic                        zero;
    shift_dir_e                  dir;
    logic [LOGC_SHIFT_WIDTH-1:0] amt;
    logic [LOGC_NORM_WIDTH-1:0]  mant;
  } s1_rec_t;

endpackage

// File: rtl/logc_shift.sv
// Combinational bidirectional mantissa shifter for the expander's second stage.
// With LOGC_EXPAND_SAT_EN defined it also flags bits pushed past the output width.
module logc_shift #(
  parameter int DATA_WIDTH  = 48,
  parameter int NORM_WIDTH  = 17,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                   i_zero,
  input  logic                   i_left,
  input  logic [SHIFT_WIDTH-1:0] i_amt,
  input  logic [NORM_WIDTH-1:0]  i_mant,
  output logic [DATA_WIDTH-1:0]  o_data
`ifdef LOGC_EXPAND_SAT_EN
  , output logic                 o_ovf
`endif
);

  // The overflow build keeps enough headroom above the output for the largest left shift.
`ifdef LOGC_EXPAND_SAT_EN
  localparam int WIDE = DATA_WIDTH + NORM_WIDTH;
`else
  localparam int WIDE = DATA_WIDTH;
`endif

  logic [WIDE-1:0] w_ext;
  logic [WIDE-1:0] w_wide;

  assign w_ext = WIDE'(i_mant);

  always_comb begin
    w_wide = {WIDE{1'b0}};
    if (i_zero) begin
      w_wide = {WIDE{1'b0}};
    end else if (i_left) begin
      w_wide = w_ext << i_amt;
    end else begin
      w_wide = w_ext >> i_amt;
    end
  end

  assign o_data = w_wide[DATA_WIDTH-1:0];
`ifdef LOGC_EXPAND_SAT_EN
  assign o_ovf  = |w_wide[WIDE-1:DATA_WIDTH];
`endif

endmodule

// File: rtl/logc_expand.sv
// logc_expand: 2-stage (exponent, mantissa) to linear fixed-point expander with valid/ready flow.
// Define LOGC_EXPAND_SAT_EN for saturation on overflow and the ovf output.
module logc_expand
  import logc_pkg::*;
#(
  parameter int DATA_WIDTH  = LOGC_DATA_WIDTH,
  parameter int FRAC_WIDTH  = LOGC_FRAC_WIDTH,
  parameter int NORM_WIDTH  = FRAC_WIDTH + 1,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHIFT_WIDTH-1:0] comp_int,
  input  logic [NORM_WIDTH-1:0]  comp_frac,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_out
`ifdef LOGC_EXPAND_SAT_EN
  , output logic                 ovf
`endif
);

  localparam logic [SHIFT_WIDTH-1:0] FRAC_SH = SHIFT_WIDTH'(FRAC_WIDTH);

  s1_rec_t                 r_s1;
  s1_rec_t                 w_s1_next;
  logic                    r_s1_valid;
  logic                    r_s2_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   w_sh_data;
  logic                    w_s1_adv;
  logic                    w_s2_load;
  logic                    w_left;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_adv  = w_s2_load || !r_s1_valid;
  assign in_ready  = w_s1_adv;

  // Split the exponent into a direction and a non-negative shift amount.
  always_comb begin
    w_s1_next      = '0;
    w_s1_next.zero = (comp_frac == ZERO_MANT);
    w_s1_next.mant = comp_frac;
    if (comp_int >= FRAC_SH) begin
      w_s1_next.dir = DIR_LEFT;
      w_s1_next.amt = comp_int - FRAC_SH;
    end else begin
      w_s1_next.dir = DIR_RIGHT;
      w_s1_next.amt = FRAC_SH - comp_int;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_s1_next;
      end
    end
  end

  assign w_left = (r_s1.dir == DIR_LEFT);

`ifdef LOGC_EXPAND_SAT_EN
  logic w_sh_ovf;
  logic r_ovf;
`endif

  logc_shift #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NORM_WIDTH  (NORM_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shift (
    .i_zero (r_s1.zero),
    .i_left (w_left),
    .i_amt  (r_s1.amt),
    .i_mant (r_s1.mant),
    .o_data (w_sh_data)
`ifdef LOGC_EXPAND_SAT_EN
    , .o_ovf (w_sh_ovf)
`endif
  );

  // Output register holds its value while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_data     <= {DATA_WIDTH{1'b0}};
`ifdef LOGC_EXPAND_SAT_EN
      r_ovf      <= 1'b0;
`endif
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
`ifdef LOGC_EXPAND_SAT_EN
        r_data <= w_sh_ovf ? {DATA_WIDTH{1'b1}} : w_sh_data;
        r_ovf  <= w_sh_ovf;
`else
        r_data <= w_sh_data;
`endif
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign data_out  = r_data;
`ifdef LOGC_EXPAND_SAT_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_logc_expand.sv
// Self-checking bench for logc_expand: directed cases plus randomized traffic against an arithmetic model.
module tb_logc_expand;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  comp_int;
  logic [16:0] comp_frac;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] data_out;
`ifdef LOGC_EXPAND_SAT_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  logc_expand dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .comp_int  (comp_int),
    .comp_frac (comp_frac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef LOGC_EXPAND_SAT_EN
    , .ovf     (ovf)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic [48:0] exp_q[$];
  int          n_acc = 0;
  int          n_out = 0;
  bit          acc_now;
  bit          out_now;

`ifdef LOGC_EXPAND_SAT_EN
  localparam logic [47:0] OVF_EXP = 48'hFFFF_FFFF_FFFF;
`else
  localparam logic [47:0] OVF_EXP = 48'h8000_0000_0000;
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Linear value of the pair with unbounded precision, then saturate or truncate.
  function automatic logic [47:0] model(input int ci, input logic [16:0] cf, output bit o);
    logic [127:0] full;
    if (cf == 17'd0)   full = 128'd0;
    else if (ci >= 16) full = 128'(cf) * (128'd1 << (ci - 16));
    else               full = 128'(cf) / (128'd1 << (16 - ci));
    o = (full >= (128'd1 << 48));
`ifdef LOGC_EXPAND_SAT_EN
    if (o) return 48'hFFFF_FFFF_FFFF;
`endif
    return full[47:0];
  endfunction

  task automatic step(input bit v, input logic [5:0] ci, input logic [16:0] cf, input bit ordy,
                      input logic [47:0] ed, input bit eo);
    logic [48:0] e;
    in_valid  = v;
    comp_int  = ci;
    comp_frac = cf;
    out_ready = ordy;
    #1;
    out_now = out_valid && out_ready;
    acc_now = in_valid && in_ready;
    if (out_now) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("data_out", 64'(data_out), 64'(e[47:0]));
`ifdef LOGC_EXPAND_SAT_EN
        check_val("ovf", 64'(ovf), 64'(e[48]));
`endif
      end
      n_out++;
    end
    if (acc_now) begin
      exp_q.push_back({eo, ed});
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [5:0] ci, input logic [16:0] cf, input logic [47:0] ed, input bit eo);
    bit done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1'b1, ci, cf, 1'b1, ed, eo);
      done = acc_now;
    end
    check_val("send_accept", 64'(done), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
      step(1'b0, 6'd0, 17'd0, 1'b1, 48'd0, 1'b0);
    end
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [5:0]  p_int[3]  = '{6'd16, 6'd17, 6'd0};
  logic [16:0] p_frac[3] = '{17'h10000, 17'h1D62A, 17'h10000};
  logic [47:0] p_exp[3]  = '{48'd65536, 48'd240724, 48'd1};

  initial begin
    int          idx;
    int          out_base;
    bit          o;
    logic [5:0]  ci;
    logic [16:0] cf;
    logic [47:0] ed;

    reset = 1'b1; in_valid = 1'b0; comp_int = 6'd0; comp_frac = 17'd0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_data_out", 64'(data_out), 64'd0);
    reset = 1'b0;
    #1;
    check_val("rel_in_ready", 64'(in_ready), 64'd1);
    check_val("rel_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Unity sample and its latency through both registers
    step(1'b1, 6'd16, 17'h10000, 1'b1, 48'd65536, 1'b0);
    check_val("lat_accept", 64'(acc_now), 64'd1);
    check_val("lat_edge1_valid", 64'(out_valid), 64'd0);
    step(1'b0, 6'd0, 17'd0, 1'b1, 48'd0, 1'b0);
    check_val("lat_edge2_valid", 64'(out_valid), 64'd1);
    check_val("lat_edge2_data", 64'(data_out), 64'd65536);
    drain();

    send(6'd16, 17'h1D62A, 48'd120362, 1'b0);
    send(6'd17, 17'h1D62A, 48'd240724, 1'b0);
    send(6'd0,  17'h10000, 48'd1,      1'b0);
    send(6'd5,  17'h00000, 48'd0,      1'b0);
    send(6'd63, 17'h1FFFF, OVF_EXP,    1'b1);
    send(6'd16, 17'h10000, 48'd65536,  1'b0);
    drain();

    // Backpressure: out_ready low for 5 cycles while offering 3 pairs
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, p_int[idx], p_frac[idx], 1'b0, p_exp[idx], 1'b0);
      if (acc_now) idx++;
      if (c >= 1) begin
        check_val("bp_hold_valid", 64'(out_valid), 64'd1);
        check_val("bp_hold_data", 64'(data_out), 64'd65536);
      end
    end
    check_val("bp_accepts", 64'(idx), 64'd2);
    #1;
    check_val("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_base = n_out;
    step(1'b1, p_int[2], p_frac[2], 1'b1, p_exp[2], 1'b0);
    check_val("bp_release_accept", 64'(acc_now), 64'd1);
    step(1'b0, 6'd0, 17'd0, 1'b1, 48'd0, 1'b0);
    step(1'b0, 6'd0, 17'd0, 1'b1, 48'd0, 1'b0);
    check_val("bp_release_rate", 64'(n_out - out_base), 64'd3);
    drain();

    // Reset with two samples in flight
    step(1'b1, 6'd16, 17'h1D62A, 1'b0, 48'd120362, 1'b0);
    step(1'b1, 6'd17, 17'h1D62A, 1'b0, 48'd240724, 1'b0);
    check_val("mid_two_in_flight", 64'(exp_q.size()), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_data_out", 64'(data_out), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    send(6'd0, 17'h10000, 48'd1, 1'b0);
    drain();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      ci = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 7))
        0:       cf = 17'd0;
        1, 2, 3: cf = {1'b1, 16'($urandom)};
        default: cf = 17'($urandom);
      endcase
      ed = model(int'(ci), cf, o);
      step(($urandom_range(0, 9) < 7), ci, cf, ($urandom_range(0, 9) < 7), ed, o);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
